// File: rtl/booth_seq_mult_pkg.sv
// ============================================================================
//  booth_seq_mult_pkg
//  Shared types and constants for the sequential radix-2 Booth multiplier.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package booth_seq_mult_pkg;

    localparam int C_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_ADD = 2'd1,
        OP_SUB = 2'd2
    } booth_op_t;

    // Radix-2 Booth recoding of the current multiplier bit pair {Q[0], q_m1}.
    function automatic booth_op_t booth_decode(input logic q0, input logic qm1);
        case ({q0, qm1})
            2'b01:   return OP_ADD;
            2'b10:   return OP_SUB;
            default: return OP_NOP;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/booth_seq_mult_step.sv
// ============================================================================
//  booth_step
//  One combinational Booth iteration: add/sub of M then arithmetic right shift.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module booth_step
    import booth_seq_mult_pkg::*;
#(
    parameter int WIDTH = C_DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   i_a,
    input  logic [WIDTH-1:0] i_q,
    input  logic             i_qm1,
    input  logic [WIDTH:0]   i_m,
    output logic [WIDTH:0]   o_a,
    output logic [WIDTH-1:0] o_q,
    output logic             o_qm1
);

    booth_op_t        w_op;
    logic [WIDTH:0]   w_sum;

    always_comb begin
        w_op  = booth_decode(i_q[0], i_qm1);
        w_sum = i_a;
        case (w_op)
            OP_ADD:  w_sum = i_a + i_m;
            OP_SUB:  w_sum = i_a - i_m;
            default: w_sum = i_a;
        endcase
        // Arithmetic shift of the concatenation {A, Q, q_m1} by one place.
        o_a   = {w_sum[WIDTH], w_sum[WIDTH:1]};
        o_q   = {w_sum[0], i_q[WIDTH-1:1]};
        o_qm1 = i_q[0];
    end

endmodule

`default_nettype wire

// File: rtl/booth_seq_mult.sv
// ============================================================================
//  booth_seq_mult
//  Sequential radix-2 Booth multiplier, signed WIDTH x WIDTH -> 2*WIDTH.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module booth_seq_mult
    import booth_seq_mult_pkg::*;
#(
    parameter int WIDTH = C_DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int              C_CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(WIDTH - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   w_accept;

    logic [WIDTH:0]         r_a;
    logic [WIDTH:0]         r_m;
    logic [WIDTH-1:0]       r_q;
    logic                   r_qm1;
    logic [C_CNT_W-1:0]     r_cnt;
    logic                   r_busy;
    logic                   r_done;
    logic [2*WIDTH-1:0]     r_product;

    logic [WIDTH:0]         w_a_nxt;
    logic [WIDTH-1:0]       w_q_nxt;
    logic                   w_qm1_nxt;

    booth_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_a   (r_a),
        .i_q   (r_q),
        .i_qm1 (r_qm1),
        .i_m   (r_m),
        .o_a   (w_a_nxt),
        .o_q   (w_q_nxt),
        .o_qm1 (w_qm1_nxt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == C_CNT_LAST) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a       <= '0;
            r_m       <= '0;
            r_q       <= '0;
            r_qm1     <= 1'b0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            r_done <= (r_state == S_DONE);
            if (w_accept) begin
                // Extra sign bit on M and A keeps A - M exact for M = -2^(WIDTH-1).
                r_m    <= {a[WIDTH-1], a};
                r_q    <= b;
                r_a    <= '0;
                r_qm1  <= 1'b0;
                r_cnt  <= '0;
                r_busy <= 1'b1;
            end
            if (r_state == S_CALC) begin
                r_a   <= w_a_nxt;
                r_q   <= w_q_nxt;
                r_qm1 <= w_qm1_nxt;
                r_cnt <= r_cnt + C_CNT_W'(1);
            end
            if (r_state == S_DONE) begin
                r_product <= {r_a[WIDTH-1:0], r_q};
                r_busy    <= 1'b0;
            end
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_product;

endmodule

`default_nettype wire

// File: tb/tb_booth_seq_mult.sv
// ============================================================================
//  tb_booth_seq_mult
//  Directed and random self-checking bench for booth_seq_mult (WIDTH = 8).
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_booth_seq_mult;

    localparam int C_WIDTH = 8;

    logic                   clk;
    logic                   rst;
    logic                   start;
    logic [C_WIDTH-1:0]     a;
    logic [C_WIDTH-1:0]     b;
    logic                   busy;
    logic                   done;
    logic [2*C_WIDTH-1:0]   product;

    int n_checks = 0;
    int n_errors = 0;

    booth_seq_mult #(
        .WIDTH (C_WIDTH)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts one multiply, scrambles operands while busy, waits for done.
    task automatic run_op(input logic [7:0] op_a, input logic [7:0] op_b,
                          input logic [15:0] exp, input bit jam_start);
        int edges;
        int busy_cycles;
        a     = op_a;
        b     = op_b;
        start = 1'b1;
        tick();
        start = 1'b0;
        edges = 0;
        busy_cycles = 0;
        while (!done && edges < 40) begin
            if (busy) busy_cycles++;
            a = 8'($urandom);
            b = 8'($urandom);
            if (jam_start) start = 1'($urandom_range(0, 1));
            tick();
            edges++;
        end
        start = 1'b0;
        chk("latency", edges, 9);
        chk("busy_cycles", busy_cycles, 9);
        chk("product", {16'h0, product}, {16'h0, exp});
        tick();
        chk("done_pulse", {31'h0, done}, 32'h0);
    endtask

    initial begin
        int edges;
        int done_seen;
        logic signed [7:0]  ra;
        logic signed [7:0]  rb;
        logic signed [15:0] rexp;

        rst   = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #12;
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_product", {16'h0, product}, 32'h0);
        tick();
        rst = 1'b1;
        tick();

        // 3 * 5 = 15, and the product must hold after done drops.
        run_op(8'd3, 8'd5, 16'h000F, 1'b0);
        tick();
        tick();
        chk("hold_product", {16'h0, product}, 32'h0000_000F);

        run_op(8'h80, 8'h80, 16'h4000, 1'b0);   // -128 * -128 = 16384
        run_op(8'h7F, 8'h80, 16'hC080, 1'b0);   //  127 * -128 = -16256
        run_op(8'hFF, 8'h01, 16'hFFFF, 1'b0);   //   -1 *    1 = -1
        run_op(8'h00, 8'h80, 16'h0000, 1'b1);   //    0 * -128 = 0, start jammed while busy

        // Back-to-back: start held high, second operands presented on the done cycle.
        a     = 8'd2;
        b     = 8'd3;
        start = 1'b1;
        tick();
        edges = 0;
        while (!done && edges < 40) begin
            a = 8'($urandom);
            b = 8'($urandom);
            tick();
            edges++;
        end
        chk("b2b_first_lat", edges, 9);
        chk("b2b_first", {16'h0, product}, 32'h0000_0006);
        a = 8'd4;
        b = 8'hFE;
        tick();
        chk("b2b_done_fall", {31'h0, done}, 32'h0);
        chk("b2b_busy_again", {31'h0, busy}, 32'h1);
        edges = 1;
        while (!done && edges < 40) begin
            a = 8'($urandom);
            b = 8'($urandom);
            tick();
            edges++;
        end
        start = 1'b0;
        chk("b2b_period", edges, 10);
        chk("b2b_second", {16'h0, product}, 32'h0000_FFF8);
        tick();

        // Reset mid-operation aborts with no done.
        a     = 8'd7;
        b     = 8'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        #2;
        rst = 1'b0;
        #1;
        chk("abort_busy", {31'h0, busy}, 32'h0);
        chk("abort_done", {31'h0, done}, 32'h0);
        chk("abort_product", {16'h0, product}, 32'h0);
        tick();
        rst = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done || busy) done_seen++;
        end
        chk("abort_no_done", done_seen, 0);

        // Random signed operands against a reference product.
        for (int i = 0; i < 1000; i++) begin
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rexp = ra * rb;
            run_op(ra, rb, rexp, 1'(i % 2));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
